// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low matrix keypad, debounces press and release, emits one code per press.
// Latency: DEBOUNCE_CNT cycles from detection to Key_valid, plus 2 synchronizer cycles on Row.
// No backpressure: Key_valid is a single-cycle pulse, and Number/Key_code hold until the next press.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic        CLK_in,
    input  logic        RST_n,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [3:0]  Key_code,
    output logic        Key_valid,
    output logic [15:0] Number
);

    // One shared counter serves both the column dwell and the debounce windows.
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [1:0]     row_idx_q, row_idx_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic [15:0]    number_q, number_d;
    logic [3:0]     row_meta_q, row_s_q;

    logic [1:0]     low_row;
    logic           row_bit;
    logic [3:0]     key_new;

    // Two-flop synchronizer: Row is asynchronous, idle-high because of the pull-ups.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
        end else begin
            row_meta_q <= Row;
            row_s_q    <= row_meta_q;
        end
    end

    // Lowest-index active row wins when several rows are low in the driven column.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) begin
                low_row = 2'(i);
            end
        end
    end

    assign row_bit = row_s_q[row_idx_q];
    assign key_new = {row_idx_q, col_idx_q};

    // Scan/debounce/hold state register and datapath registers.
    always_ff @(posedge CLK_in or negedge RST_n) begin
        if (!RST_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            number_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            number_q    <= number_d;
        end
    end

    // Next-state logic: column walk, press qualification, release qualification.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        number_d    = number_q;
        unique case (state_q)
            SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (row_s_q != 4'b1111) begin
                        // Column stays frozen on the one that showed activity.
                        row_idx_d = low_row;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!row_bit) begin
                    if (cnt_q == DB_LAST) begin
                        key_valid_d = 1'b1;
                        key_code_d  = key_new;
                        number_d    = {number_q[11:0], key_new};
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    // Bounce: abandon this column and keep scanning.
                    cnt_d     = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = SCAN;
                end
            end
            HOLD: begin
                if (row_bit) begin
                    if (cnt_q == DB_LAST) begin
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    assign Col       = ~(4'b0001 << col_idx_q);
    assign Key_code  = key_code_q;
    assign Key_valid = key_valid_q;
    assign Number    = number_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] number;

    // Physical keypad model: pressed[r*4+c] closes the switch between row r and column c.
    logic [15:0] pressed;
    logic        direct_en;
    logic [3:0]  row_direct;
    logic [3:0]  model_row;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int dbl    = 0;
    int cyc    = 0;
    int first_pulse_cyc = -1;
    logic [3:0]  last_code = 4'd0;
    logic        prev_kv = 1'b0;
    logic [15:0] exp_num = 16'd0;
    int p0, t0, hold, r, c, lat;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .CLK_in    (clk),
        .RST_n     (rst_n),
        .Row       (row),
        .Col       (col),
        .Key_code  (key_code),
        .Key_valid (key_valid),
        .Number    (number)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        model_row = 4'b1111;
        for (int rr = 0; rr < 4; rr++) begin
            for (int cc = 0; cc < 4; cc++) begin
                if (pressed[rr*4+cc] && !col[cc]) model_row[rr] = 1'b0;
            end
        end
    end
    assign row = direct_en ? row_direct : model_row;

    // Pulse monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (key_valid === 1'b1) begin
            pulses = pulses + 1;
            last_code = key_code;
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
            if (prev_kv) dbl = dbl + 1;
        end
        prev_kv = (key_valid === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] v, input int max_cyc, input string tag);
        int k;
        k = 0;
        while (col !== v && k < max_cyc) begin
            tick(1);
            k++;
        end
        if (col !== v) check(tag, {28'd0, col}, {28'd0, v});
    endtask

    // Press one key long enough to be accepted, release, and check the single resulting pulse.
    task automatic press_key(input int pr, input int pc, input int hold_cyc, input string tag);
        logic [3:0] code;
        code = 4'(pr * 4 + pc);
        p0 = pulses;
        first_pulse_cyc = -1;
        t0 = cyc;
        pressed[pr*4+pc] = 1'b1;
        tick(hold_cyc);
        pressed[pr*4+pc] = 1'b0;
        tick(20);
        exp_num = 16'(((exp_num << 4) | {12'd0, code}) & 16'hFFFF);
        check({tag, "_pulses"}, pulses - p0, 1);
        check({tag, "_code"}, {28'd0, last_code}, {28'd0, code});
        check({tag, "_number"}, {16'd0, number}, {16'd0, exp_num});
        lat = first_pulse_cyc - t0;
        check({tag, "_latency_ok"}, (first_pulse_cyc >= 0 && lat <= 4*4 + 8 + 3) ? 1 : 0, 1);
    endtask

    initial begin
        pressed    = 16'd0;
        direct_en  = 1'b0;
        row_direct = 4'b1111;
        rst_n      = 1'b0;

        // 1: reset values, then the idle column walk.
        tick(3);
        check("rst_col", {28'd0, col}, 32'hE);
        check("rst_kv", {31'd0, key_valid}, 0);
        check("rst_code", {28'd0, key_code}, 0);
        check("rst_num", {16'd0, number}, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("walk_col", {28'd0, col}, {28'd0, ~(4'b0001 << ((k / 4) % 4))});
            tick(1);
        end

        // 2: row2/col1 held for 50 cycles.
        p0 = pulses;
        pressed[2*4+1] = 1'b1;
        tick(45);
        check("hold_col_frozen", {28'd0, col}, 32'hD);
        tick(5);
        pressed[2*4+1] = 1'b0;
        tick(5);
        check("release_col_frozen", {28'd0, col}, 32'hD);
        tick(15);
        exp_num = 16'h0009;
        check("t2_pulses", pulses - p0, 1);
        check("t2_code", {28'd0, key_code}, 32'h9);
        check("t2_number", {16'd0, number}, 32'h0009);

        // 3: 3-cycle bounce on row0 during col0.
        p0 = pulses;
        direct_en = 1'b1;
        wait_col(4'b0111, 40, "t3_wait_col3");
        wait_col(4'b1110, 40, "t3_wait_col0");
        row_direct = 4'b1110;
        tick(3);
        row_direct = 4'b1111;
        begin
            int k;
            k = 0;
            while (col === 4'b1110 && k < 30) begin
                tick(1);
                k++;
            end
        end
        check("t3_col_advance", {28'd0, col}, 32'hD);
        tick(10);
        check("t3_no_pulse", pulses - p0, 0);
        check("t3_number", {16'd0, number}, 32'h0009);
        direct_en = 1'b0;

        // 4: codes 1..5.
        press_key(0, 1, 40, "t4_k1");
        press_key(0, 2, 40, "t4_k2");
        press_key(0, 3, 40, "t4_k3");
        press_key(1, 0, 40, "t4_k4");
        press_key(1, 1, 40, "t4_k5");
        check("t4_number_const", {16'd0, number}, 32'h2345);

        // 5: rows 1 and 3 low together in col3; lower row index wins.
        p0 = pulses;
        pressed[1*4+3] = 1'b1;
        pressed[3*4+3] = 1'b1;
        tick(40);
        pressed = 16'd0;
        tick(20);
        exp_num = 16'h3457;
        check("t5_pulses", pulses - p0, 1);
        check("t5_code", {28'd0, key_code}, 32'h7);
        check("t5_number", {16'd0, number}, 32'h3457);

        // 6: reset four cycles into DEBOUNCE.
        p0 = pulses;
        wait_col(4'b1101, 40, "t6_wait_col1");
        pressed[0] = 1'b1;
        wait_col(4'b1110, 40, "t6_wait_col0");
        tick(8);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_col", {28'd0, col}, 32'hE);
        check("t6_rst_kv", {31'd0, key_valid}, 0);
        check("t6_rst_code", {28'd0, key_code}, 0);
        check("t6_rst_num", {16'd0, number}, 0);
        pressed = 16'd0;
        tick(12);
        check("t6_no_pulse", pulses - p0, 0);
        exp_num = 16'd0;
        rst_n = 1'b1;
        check("t6_restart_col0", {28'd0, col}, 32'hE);
        tick(4);
        check("t6_restart_col1", {28'd0, col}, 32'hD);

        // Randomized presses and short bounces against the keypad model.
        for (int i = 0; i < 14; i++) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                p0 = pulses;
                pressed[r*4+c] = 1'b1;
                tick(int'($urandom_range(1, 4)));
                pressed[r*4+c] = 1'b0;
                tick(15);
                check("rnd_bounce_no_pulse", pulses - p0, 0);
                check("rnd_bounce_number", {16'd0, number}, {16'd0, exp_num});
            end else begin
                hold = int'($urandom_range(32, 64));
                press_key(r, c, hold, "rnd_press");
            end
        end

        check("no_double_pulse", dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
